// File: rtl/frame_scanout.sv
// frame_scanout
// Prefetches a frame buffer in raster order and hands pixels to a consumer
// through a small FIFO. Reads are only requested while the data already in
// the FIFO plus the reads still in flight leave room for one more entry, so
// the FIFO can never overflow. A frame_start in mid-frame flushes the FIFO
// and discards the responses of reads that are still in flight.
//
// Ports
//   Clk          single clock
//   Reset        synchronous, active high
//   frame_start  one-cycle pulse, restart scanout at pixel 0
//   mem_req      read request (accepted when mem_gnt=1 in the same cycle)
//   mem_addr     linear pixel address y*H_RES+x
//   mem_gnt      arbiter grant
//   mem_rvalid   read data valid, responses return in request order
//   mem_rdata    returned {R,G,B}
//   pix_valid    FIFO non-empty
//   pix_color    FIFO head
//   pix_ready    consumer pops on pix_valid & pix_ready
//   underflow    sticky: consumer asked for a pixel while the FIFO was empty
//
// state | meaning
// IDLE  | waiting for the first frame_start, no requests
// FETCH | issuing reads under the credit limit
// DONE  | last address accepted, draining in-flight responses into the FIFO
// FLUSH | discarding responses of reads issued before a restart

module frame_scanout #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    output logic        mem_req,
    output logic [18:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [23:0] mem_rdata,
    output logic        pix_valid,
    output logic [23:0] pix_color,
    input  logic        pix_ready,
    output logic        underflow
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = PW + 1;
    localparam int          TOTAL     = H_RES * V_RES;
    localparam logic [18:0] LAST_ADDR = 19'(TOTAL - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [18:0]     r_addr;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [23:0]     r_mem [FIFO_DEPTH];
    logic            r_uf;

    logic            w_req;
    logic            w_credit_ok;
    logic            w_accept;
    logic            w_restart;
    logic            w_rv_live;
    logic            w_rv_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_last;
    logic [CW-1:0]   w_drop_load;

    // Sum of in-flight reads and stored entries is invariant under an rvalid,
    // so this credit check alone keeps the FIFO from overflowing.
    assign w_credit_ok = ({1'b0, r_out} + {1'b0, r_cnt}) < (CW+1)'(FIFO_DEPTH);
    assign w_accept    = w_req && mem_gnt;
    assign w_restart   = frame_start && (r_state == S_FETCH || r_state == S_DONE);
    // Responses with nothing in flight (e.g. reads issued before a reset) are ignored.
    assign w_rv_live   = mem_rvalid && (r_out != '0);
    assign w_rv_drop   = mem_rvalid && (r_state == S_FLUSH) && (r_drop != '0);
    // A response arriving in the restart cycle belongs to the old frame.
    assign w_push      = w_rv_live && !w_restart;
    assign w_pop       = pix_valid && pix_ready;
    assign w_last      = w_accept && (r_addr == LAST_ADDR);
    assign w_drop_load = r_out + CW'(w_accept) - CW'(w_rv_live);

    assign mem_req   = w_req;
    assign mem_addr  = r_addr;
    assign pix_valid = (r_cnt != '0);
    assign pix_color = r_mem[r_rd];
    assign underflow = r_uf;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (frame_start) w_state_nxt = S_FETCH;
            end
            S_FETCH, S_DONE: begin
                if (w_restart) begin
                    w_state_nxt = (w_drop_load != '0) ? S_FLUSH : S_FETCH;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_FLUSH: begin
                // frame_start here is ignored; the flush still has to finish.
                if (w_rv_drop && r_drop == CW'(1)) w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        if (r_state == S_FETCH) w_req = w_credit_ok;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_addr <= '0;
            r_out  <= '0;
            r_drop <= '0;
            r_cnt  <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_uf   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (frame_start) begin
                r_addr <= '0;
            end else if (w_accept) begin
                r_addr <= w_last ? 19'd0 : r_addr + 19'd1;
            end

            if (w_restart) begin
                r_out <= '0;
            end else begin
                r_out <= r_out + CW'(w_accept) - CW'(w_rv_live);
            end

            if (w_restart) begin
                r_drop <= w_drop_load;
            end else if (w_rv_drop) begin
                r_drop <= r_drop - CW'(1);
            end

            if (w_restart) begin
                r_cnt <= '0;
                r_wr  <= '0;
                r_rd  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr] <= mem_rdata;
                    r_wr        <= r_wr + PW'(1);
                end
                if (w_pop) r_rd <= r_rd + PW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end

            // Clear wins over a set in the same cycle.
            if (frame_start) begin
                r_uf <= 1'b0;
            end else if (r_state == S_FETCH && pix_ready && !pix_valid) begin
                r_uf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout
// Drives frame_scanout with a small frame (8x4) so whole frames fit in a
// short run. A memory model answers accepted reads in order one cycle later;
// each read is tagged with the frame epoch it was issued in, and only
// responses of the current epoch produce an expected pixel. Expected pixels
// are queued when the response is driven and compared when the consumer pops.

module tb_frame_scanout;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int D     = 8;
    localparam int TOTAL = H * V;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [23:0] mem_rdata;
    logic        pix_valid;
    logic [23:0] pix_color;
    logic        pix_ready;
    logic        underflow;

    always #5 Clk = ~Clk;

    frame_scanout #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .pix_valid   (pix_valid),
        .pix_color   (pix_color),
        .pix_ready   (pix_ready),
        .underflow   (underflow)
    );

    typedef struct {
        int          epoch;
        logic [18:0] addr;
    } rd_t;

    rd_t         pend[$];
    logic [23:0] sb[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          epoch    = 0;
    int          n_acc    = 0;
    int          n_pop    = 0;
    int          cyc      = 0;
    bit          done_flag = 1'b0;
    logic [18:0] exp_addr = '0;

    bit          c_rst;
    bit          c_fs;
    bit          c_ready;
    bit          c_rsp;
    int          c_gnt_mode;

    logic        s_req;
    logic        s_pv;
    logic        s_uf;
    logic [18:0] s_addr;
    logic [23:0] s_col;

    function automatic logic [23:0] color_of(input logic [18:0] a);
        return {5'h15, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick();
        bit  acc;
        bit  rv;
        rd_t r;
        Reset       = c_rst;
        frame_start = c_fs;
        pix_ready   = c_ready;
        mem_gnt     = (c_gnt_mode == 1) || (c_gnt_mode == 2 && (cyc % 2) == 1);
        rv          = c_rsp && (pend.size() > 0);
        mem_rvalid  = rv;
        mem_rdata   = rv ? color_of(pend[0].addr) : 24'h0;
        #1;
        s_req  = mem_req;
        s_addr = mem_addr;
        s_pv   = pix_valid;
        s_col  = pix_color;
        s_uf   = underflow;
        if (!c_rst) begin
            chk("pix_valid", s_pv, sb.size() != 0);
            if (s_pv && c_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_nodata", s_pv, 0);
                end else begin
                    chk("pix_color", s_col, sb.pop_front());
                    n_pop++;
                end
            end
        end
        if (rv) begin
            r = pend.pop_front();
            if (!c_rst && !c_fs && r.epoch == epoch) sb.push_back(color_of(r.addr));
        end
        acc = !c_rst && (s_req === 1'b1) && mem_gnt;
        if (acc) begin
            chk("mem_addr", s_addr, exp_addr);
            r.epoch = epoch;
            r.addr  = s_addr;
            pend.push_back(r);
            n_acc++;
            if (s_addr == 19'(TOTAL - 1)) done_flag = 1'b1;
            exp_addr = (exp_addr == 19'(TOTAL - 1)) ? 19'd0 : exp_addr + 19'd1;
        end
        if (c_rst || c_fs) begin
            sb.delete();
            epoch++;
            exp_addr  = '0;
            n_acc     = 0;
            n_pop     = 0;
            done_flag = 1'b0;
        end
        cyc++;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic pulse_fs();
        c_fs = 1'b1;
        tick();
        c_fs = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        int budget;
        budget = 2000;
        while (!(done_flag && pend.size() == 0 && sb.size() == 0) && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_timeout"}, budget > 0, 1);
        chk({tag, "_pixels"}, n_pop, TOTAL);
        chk({tag, "_accepts"}, n_acc, TOTAL);
    endtask

    initial begin
        int b;
        c_rst = 1'b1; c_fs = 1'b0; c_ready = 1'b0; c_rsp = 1'b1; c_gnt_mode = 0;
        tick();
        tick();
        c_rst = 1'b0;
        tick();
        chk("rst_req", s_req, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_pv", s_pv, 0);
        chk("rst_color", s_col, 0);
        chk("rst_uf", s_uf, 0);

        // IDLE: no requests and no underflow even with grant and ready high
        c_gnt_mode = 1; c_ready = 1'b1;
        tick();
        tick();
        chk("idle_no_req", s_req, 0);
        chk("idle_no_uf", s_uf, 0);

        // full frame, free-flowing
        pulse_fs();
        run_to_done("full");
        tick();
        chk("done_req", s_req, 0);
        chk("done_addr", s_addr, 0);
        chk("full_uf", s_uf, 1);

        // consumer stalled: credit limit caps accepts at FIFO depth
        c_ready = 1'b0;
        pulse_fs();
        repeat (30) tick();
        chk("bp_accepts", n_acc, D);
        chk("bp_req", s_req, 0);
        chk("bp_valid", s_pv, 1);
        chk("bp_uf", s_uf, 0);
        c_ready = 1'b1;
        run_to_done("bp");

        // grant toggling every other cycle
        c_gnt_mode = 2;
        pulse_fs();
        run_to_done("toggle");
        c_gnt_mode = 0;
        tick();

        // underflow set, hold, clear, and same-cycle set/clear
        c_ready = 1'b1;
        pulse_fs();
        tick();
        chk("uf_clear", s_uf, 0);
        tick();
        chk("uf_set", s_uf, 1);
        c_ready = 1'b0;
        repeat (4) tick();
        chk("uf_hold", s_uf, 1);
        c_ready = 1'b1;
        pulse_fs();
        c_ready = 1'b0;
        tick();
        chk("uf_fs_same_cycle", s_uf, 0);

        // restart with 3 in flight, an accept and an rvalid in the same cycle
        c_rsp = 1'b0; c_gnt_mode = 1;
        b = 20;
        while (pend.size() < 3 && b > 0) begin
            tick();
            b--;
        end
        chk("flush_setup", pend.size(), 3);
        c_rsp = 1'b1;
        pulse_fs();
        chk("fs_accept_req", s_req, 1);
        c_gnt_mode = 0;
        tick();
        chk("flush_req0", s_req, 0);
        tick();
        chk("flush_req1", s_req, 0);
        tick();
        chk("flush_req2", s_req, 0);
        tick();
        chk("flush_exit_req", s_req, 1);
        chk("flush_pv", s_pv, 0);
        c_gnt_mode = 1; c_ready = 1'b1;
        run_to_done("after_flush");

        // reset mid-FETCH with 2 in flight
        c_rsp = 1'b0; c_ready = 1'b1; c_gnt_mode = 1;
        pulse_fs();
        b = 20;
        while (pend.size() < 2 && b > 0) begin
            tick();
            b--;
        end
        chk("rst_setup", pend.size(), 2);
        c_gnt_mode = 0;
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0;
        c_rsp = 1'b1;
        tick();
        chk("mid_rst_req", s_req, 0);
        chk("mid_rst_addr", s_addr, 0);
        chk("mid_rst_pv", s_pv, 0);
        chk("mid_rst_color", s_col, 0);
        chk("mid_rst_uf", s_uf, 0);
        repeat (3) begin
            tick();
            chk("late_rv_pv", s_pv, 0);
            chk("late_rv_req", s_req, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
